// File: rtl/conn_sup_pkg.sv
// rtl/conn_sup_pkg.sv - shared types and constants for the connection supervisor
//
// Purpose: per-channel link FSM state encodings and statistics widths used by
// conn_chan and conn_supervisor.
package conn_sup_pkg;

   typedef enum logic [1:0] {
      ST_WAIT    = 2'b00,
      ST_LINKED  = 2'b01,
      ST_LOST    = 2'b10,
      ST_RECOVER = 2'b11
   } conn_state_e;

   localparam int STAT_W     = 16;
   localparam int STAT_SEL_W = 4;

endpackage

// File: rtl/conn_chan.sv
// rtl/conn_chan.sv - single-link watchdog: idle counter, link FSM, recovery count
//
// Purpose: supervises one link from its frame-received strobe and reports
// whether the link is usable.
// Optional feature macro: STATS_EN (per-channel saturating loss counter).
// Ports:
//   sys_clk, rst        clock, synchronous active-high reset
//   i_recv              single-cycle frame-received strobe
//   i_enable            supervise enable; 0 holds the channel in WAIT
//   i_stat_clr          clear the loss counter (STATS_EN only)
//   o_lost              registered, 1 = not LINKED while enabled
//   o_lost_pulse        one-cycle strobe on LINKED->LOST
//   o_recover_pulse     one-cycle strobe on LOST/RECOVER->LINKED
//   o_state             current FSM state
//   o_stat_count        loss counter (0 when STATS_EN is undefined)
module conn_chan
   import conn_sup_pkg::*;
#(
   parameter int TIMEOUT        = 25_000_000,
   parameter int CNT_W          = 32,
   parameter int RECOVER_FRAMES = 2
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              i_recv,
   input  logic              i_enable,
   input  logic              i_stat_clr,
   output logic              o_lost,
   output logic              o_lost_pulse,
   output logic              o_recover_pulse,
   output logic [1:0]        o_state,
   output logic [STAT_W-1:0] o_stat_count
);

   localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
   localparam logic [3:0]       REC_N = 4'(RECOVER_FRAMES);

   conn_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       rec_q, rec_d;
   logic             lost_q, lost_d;
   logic             lost_pulse_q, lost_pulse_d;
   logic             recover_pulse_q, recover_pulse_d;
   logic             expire;

   always_comb begin
      state_d         = state_q;
      rec_d           = rec_q;
      lost_pulse_d    = 1'b0;
      recover_pulse_d = 1'b0;
      cnt_d           = i_recv ? '0 : ((cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1));
      // Expiry is the edge on which the idle count reaches TIMEOUT, so a link
      // whose last frame was at edge t drops at edge t+TIMEOUT.
      expire          = !i_recv && (cnt_d == TMO);

      if (!i_enable) begin
         state_d = ST_WAIT;
         cnt_d   = '0;
         rec_d   = '0;
         expire  = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               // Leaving WAIT never strobes: it is not a recovery from a loss.
               if (i_recv) begin
                  if (REC_N == 4'd1) begin
                     state_d = ST_LINKED;
                  end else begin
                     state_d = ST_RECOVER;
                     rec_d   = 4'd1;
                  end
               end
            end
            ST_LINKED: begin
               if (expire) begin
                  state_d      = ST_LOST;
                  lost_pulse_d = 1'b1;
               end
            end
            ST_LOST: begin
               if (i_recv) begin
                  if (REC_N == 4'd1) begin
                     state_d         = ST_LINKED;
                     recover_pulse_d = 1'b1;
                  end else begin
                     state_d = ST_RECOVER;
                     rec_d   = 4'd1;
                  end
               end
            end
            ST_RECOVER: begin
               if (i_recv) begin
                  if (rec_q + 4'd1 == REC_N) begin
                     state_d         = ST_LINKED;
                     recover_pulse_d = 1'b1;
                     rec_d           = '0;
                  end else begin
                     rec_d = rec_q + 4'd1;
                  end
               end else if (expire) begin
                  // Link never came up, so this is not a new loss event.
                  state_d = ST_LOST;
                  rec_d   = '0;
               end
            end
         endcase
      end

      lost_d = (state_d != ST_LINKED) && i_enable;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q         <= ST_WAIT;
         cnt_q           <= '0;
         rec_q           <= '0;
         lost_q          <= 1'b0;
         lost_pulse_q    <= 1'b0;
         recover_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         rec_q           <= rec_d;
         lost_q          <= lost_d;
         lost_pulse_q    <= lost_pulse_d;
         recover_pulse_q <= recover_pulse_d;
      end
   end

   assign o_lost          = lost_q;
   assign o_lost_pulse    = lost_pulse_q;
   assign o_recover_pulse = recover_pulse_q;
   assign o_state         = state_q;

`ifdef STATS_EN
   logic [STAT_W-1:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (i_stat_clr) begin
         stat_d = '0;
      end else if (lost_pulse_d && (stat_q != '1)) begin
         stat_d = stat_q + STAT_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign o_stat_count = stat_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = i_stat_clr;
   assign o_stat_count    = '0;
`endif

endmodule

// File: rtl/conn_supervisor.sv
// rtl/conn_supervisor.sv - multi-channel link-health supervisor
//
// Purpose: CHANNELS independent link watchdogs with combined lost flags.
// Optional feature macro: STATS_EN (per-channel loss statistics readout).
// Ports:
//   sys_clk, rst         clock, synchronous active-high reset
//   i_recv[CHANNELS]     per-channel frame-received strobe
//   i_enable[CHANNELS]   per-channel supervise enable
//   o_lost               per-channel registered lost flag (masked by enable)
//   o_lost_pulse         per-channel LINKED->LOST strobe
//   o_recover_pulse      per-channel LOST/RECOVER->LINKED strobe
//   o_any_lost           any channel lost
//   o_all_lost           every enabled channel lost, 0 when none enabled
//   o_state              per-channel state, channel i at [2i+1:2i]
//   i_stat_sel           statistics channel select
//   i_stat_clr           clear all statistics counters
//   o_stat_count         registered loss count of the selected channel
module conn_supervisor
   import conn_sup_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int TIMEOUT        = 25_000_000,
   parameter int CNT_W          = 32,
   parameter int RECOVER_FRAMES = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   i_recv,
   input  logic [CHANNELS-1:0]   i_enable,
   output logic [CHANNELS-1:0]   o_lost,
   output logic [CHANNELS-1:0]   o_lost_pulse,
   output logic [CHANNELS-1:0]   o_recover_pulse,
   output logic                  o_any_lost,
   output logic                  o_all_lost,
   output logic [2*CHANNELS-1:0] o_state,
   input  logic [STAT_SEL_W-1:0] i_stat_sel,
   input  logic                  i_stat_clr,
   output logic [STAT_W-1:0]     o_stat_count
);

   logic [CHANNELS-1:0]              en_q, en_d;
   logic [CHANNELS-1:0][STAT_W-1:0]  chan_stat;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      conn_chan #(
         .TIMEOUT        (TIMEOUT),
         .CNT_W          (CNT_W),
         .RECOVER_FRAMES (RECOVER_FRAMES)
      ) u_chan (
         .sys_clk         (sys_clk),
         .rst             (rst),
         .i_recv          (i_recv[i]),
         .i_enable        (i_enable[i]),
         .i_stat_clr      (i_stat_clr),
         .o_lost          (o_lost[i]),
         .o_lost_pulse    (o_lost_pulse[i]),
         .o_recover_pulse (o_recover_pulse[i]),
         .o_state         (o_state[2*i +: 2]),
         .o_stat_count    (chan_stat[i])
      );
   end

   // Enable is registered on the same edge as the lost flags so the all-lost
   // reduction compares values that belong to the same cycle.
   always_comb begin
      en_d = i_enable;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         en_q <= '0;
      end else begin
         en_q <= en_d;
      end
   end

   assign o_any_lost = |o_lost;
   assign o_all_lost = (en_q != '0) && (o_lost == en_q);

`ifdef STATS_EN
   logic [15:0][STAT_W-1:0] stat_pad;
   logic [STAT_W-1:0]       stat_count_q, stat_count_d;

   // Unpopulated selects read as zero.
   for (genvar i = 0; i < 16; i++) begin : g_pad
      if (i < CHANNELS) begin : g_used
         assign stat_pad[i] = chan_stat[i];
      end else begin : g_zero
         assign stat_pad[i] = '0;
      end
   end

   always_comb begin
      stat_count_d = stat_pad[i_stat_sel];
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         stat_count_q <= '0;
      end else begin
         stat_count_q <= stat_count_d;
      end
   end

   assign o_stat_count = stat_count_q;
`else
   logic unused_stats;
   assign unused_stats = ^{chan_stat, i_stat_sel};
   assign o_stat_count = '0;
`endif

endmodule

// File: tb/tb_conn_supervisor.sv
// tb/tb_conn_supervisor.sv - self-checking bench for conn_supervisor
module tb_conn_supervisor;

   localparam int CH  = 4;
   localparam int TMO = 10;
   localparam int RF  = 3;

   localparam logic [1:0] S_WAIT = 2'd0, S_LINKED = 2'd1, S_LOST = 2'd2, S_RECOVER = 2'd3;

   logic            sys_clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   i_recv, i_enable;
   logic [CH-1:0]   o_lost, o_lost_pulse, o_recover_pulse;
   logic            o_any_lost, o_all_lost;
   logic [2*CH-1:0] o_state;
   logic [3:0]      i_stat_sel;
   logic            i_stat_clr;
   logic [15:0]     o_stat_count;

   conn_supervisor #(
      .CHANNELS       (CH),
      .TIMEOUT        (TMO),
      .CNT_W          (8),
      .RECOVER_FRAMES (RF)
   ) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .i_recv          (i_recv),
      .i_enable        (i_enable),
      .o_lost          (o_lost),
      .o_lost_pulse    (o_lost_pulse),
      .o_recover_pulse (o_recover_pulse),
      .o_any_lost      (o_any_lost),
      .o_all_lost      (o_all_lost),
      .o_state         (o_state),
      .i_stat_sel      (i_stat_sel),
      .i_stat_clr      (i_stat_clr),
      .o_stat_count    (o_stat_count)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [CH-1:0]   lost;
      logic [CH-1:0]   lp;
      logic [CH-1:0]   rp;
      logic            any;
      logic            all;
      logic [2*CH-1:0] state;
   } obs_t;

   obs_t          exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [CH-1:0] seen_lp, seen_rp;

   logic [1:0] m_st   [CH];
   int         m_idle [CH];
   int         m_rec  [CH];

   // Reference model: advance one edge from the inputs being driven now and
   // queue the outputs expected after that edge.
   task automatic model_push();
      obs_t e;
      e = '0;
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_st[c] = S_WAIT; m_idle[c] = 0; m_rec[c] = 0;
         end
         exp_q.push_back(e);
         return;
      end
      for (int c = 0; c < CH; c++) begin
         if (!i_enable[c]) begin
            m_st[c] = S_WAIT; m_idle[c] = 0; m_rec[c] = 0;
         end else begin
            bit r, to;
            int idle_new;
            r        = i_recv[c];
            idle_new = r ? 0 : ((m_idle[c] < TMO) ? m_idle[c] + 1 : TMO);
            to       = !r && (idle_new == TMO);
            case (m_st[c])
               S_WAIT:    if (r) begin m_st[c] = S_RECOVER; m_rec[c] = 1; end
               S_LINKED:  if (to) begin m_st[c] = S_LOST; e.lp[c] = 1'b1; end
               S_LOST:    if (r) begin m_st[c] = S_RECOVER; m_rec[c] = 1; end
               default: begin
                  if (r) begin
                     m_rec[c]++;
                     if (m_rec[c] == RF) begin
                        m_st[c] = S_LINKED; e.rp[c] = 1'b1; m_rec[c] = 0;
                     end
                  end else if (to) begin
                     m_st[c] = S_LOST; m_rec[c] = 0;
                  end
               end
            endcase
            m_idle[c] = idle_new;
            e.lost[c] = (m_st[c] != S_LINKED);
         end
         e.state[2*c +: 2] = m_st[c];
      end
      e.any = |e.lost;
      e.all = (i_enable != '0) && ((e.lost & i_enable) == i_enable);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      obs_t got, e;
      model_push();
      @(posedge sys_clk);
      #1;
      got.lost  = o_lost;
      got.lp    = o_lost_pulse;
      got.rp    = o_recover_pulse;
      got.any   = o_any_lost;
      got.all   = o_all_lost;
      got.state = o_state;
      e = exp_q.pop_front();
      n_tests++;
      assert (got === e) else begin
         n_fail++;
         $error("FAIL cycle observed=%h expected=%h", got, e);
      end
      seen_lp |= o_lost_pulse;
      seen_rp |= o_recover_pulse;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse_recv(input logic [CH-1:0] m);
      i_recv = m;
      tick();
      i_recv = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; i_recv = '0; i_enable = 4'hF; i_stat_sel = 4'd0; i_stat_clr = 1'b0;
      seen_lp = '0; seen_rp = '0;
      run(2);
      chk("reset_lost", 32'(o_lost), 32'h0);
      chk("reset_all", 32'(o_all_lost), 32'h0);
      chk("reset_state", 32'(o_state), 32'h0);

      // 1: release, nobody talks
      rst = 1'b0;
      tick();
      chk("t1_lost", 32'(o_lost), 32'hF);
      chk("t1_all", 32'(o_all_lost), 32'h1);
      chk("t1_state", 32'(o_state), 32'h00);
      run(99);
      chk("t1_no_pulses", 32'({seen_lp, seen_rp}), 32'h0);

      // 2: ch0 comes up with three frames at edges 0, 5, 10
      pulse_recv(4'h1);
      chk("t2_rec_e0", 32'(o_state[1:0]), 32'h3);
      run(4);
      pulse_recv(4'h1);
      chk("t2_rec_e5", 32'(o_state[1:0]), 32'h3);
      run(4);
      pulse_recv(4'h1);
      chk("t2_linked_lost", 32'(o_lost[0]), 32'h0);
      chk("t2_rp", 32'(o_recover_pulse[0]), 32'h1);
      chk("t2_all", 32'(o_all_lost), 32'h0);
      tick();
      chk("t2_rp_once", 32'(o_recover_pulse[0]), 32'h0);

      // 3: frame exactly at the timeout edge keeps the link, silence drops it
      run(8);
      pulse_recv(4'h1);
      chk("t3_recv_wins", 32'(o_lost[0]), 32'h0);
      seen_lp = '0;
      run(9);
      chk("t3_before_tmo", 32'(o_lost[0]), 32'h0);
      tick();
      chk("t3_lost", 32'(o_lost[0]), 32'h1);
      chk("t3_lp", 32'(o_lost_pulse[0]), 32'h1);
      tick();
      chk("t3_lp_once", 32'(o_lost_pulse[0]), 32'h0);

      // 4: ch1 lost, partial recovery times out, then a full burst
      run(3);
      pulse_recv(4'h2); pulse_recv(4'h2); pulse_recv(4'h2);
      run(10);
      chk("t4_ch1_lost", 32'(o_state[3:2]), 32'(S_LOST));
      seen_lp = '0; seen_rp = '0;
      pulse_recv(4'h2);
      chk("t4_rec_e0", 32'(o_state[3:2]), 32'(S_RECOVER));
      run(3);
      pulse_recv(4'h2);
      run(9);
      chk("t4_rec_e13", 32'(o_state[3:2]), 32'(S_RECOVER));
      chk("t4_lost_held", 32'(o_lost[1]), 32'h1);
      tick();
      chk("t4_lost_e14", 32'(o_state[3:2]), 32'(S_LOST));
      chk("t4_no_pulse", 32'({seen_lp[1], seen_rp[1]}), 32'h0);
      pulse_recv(4'h2); pulse_recv(4'h2); pulse_recv(4'h2);
      chk("t4_recovered", 32'(o_lost[1]), 32'h0);
      chk("t4_rp", 32'(o_recover_pulse[1]), 32'h1);

      // 5: enable handling on ch2
      pulse_recv(4'h4); pulse_recv(4'h4); pulse_recv(4'h4);
      chk("t5_linked", 32'(o_lost[2]), 32'h0);
      seen_lp = '0;
      i_enable = 4'hB;
      tick();
      chk("t5_dis_lost", 32'(o_lost[2]), 32'h0);
      chk("t5_dis_state", 32'(o_state[5:4]), 32'(S_WAIT));
      i_enable = 4'hF;
      tick();
      chk("t5_reen_lost", 32'(o_lost[2]), 32'h1);
      chk("t5_no_lp", 32'(seen_lp[2]), 32'h0);
      i_enable = 4'h0;
      tick();
      chk("t5_none_all", 32'(o_all_lost), 32'h0);
      chk("t5_none_any", 32'(o_any_lost), 32'h0);
      i_enable = 4'hF;
      tick();

      // 6: loss statistics on ch1
      i_stat_sel = 4'd1;
      i_stat_clr = 1'b1;
      tick();
      i_stat_clr = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         pulse_recv(4'h2); pulse_recv(4'h2); pulse_recv(4'h2);
         run(10);
      end
      tick();
`ifdef STATS_EN
      chk("t6_count3", 32'(o_stat_count), 32'd3);
      i_stat_sel = 4'd7;
      tick();
      chk("t6_sel_oor", 32'(o_stat_count), 32'd0);
      i_stat_sel = 4'd1;
      tick();
      chk("t6_count3b", 32'(o_stat_count), 32'd3);
      i_stat_clr = 1'b1;
      tick();
      i_stat_clr = 1'b0;
      tick();
      chk("t6_cleared", 32'(o_stat_count), 32'd0);
`else
      chk("t6_stats_off", 32'(o_stat_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conn_supervisor.md
Name: conn_supervisor

Overview:
Multi-channel link-health supervisor for the UART game client. It replaces the single hard-coded connection-timeout counter with CHANNELS independent watchdogs. Each watchdog takes a frame-received strobe, tracks link state with a 4-state FSM, and requires RECOVER_FRAMES timely frames before declaring a link restored. Its outputs drive lost-connection display muxing, register-reset of the receive controller, and status LEDs.

Parameters:
CHANNELS, 4, number of supervised links (1..16)
TIMEOUT, 25_000_000, idle sys_clk cycles before a link is declared lost (>=2)
CNT_W, 32, width of each timeout counter; must hold TIMEOUT
RECOVER_FRAMES, 2, consecutive timely frames needed to return to LINKED (1..15)

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_recv  in  CHANNELS  per-channel single-cycle frame-received strobe
i_enable  in  CHANNELS  per-channel supervise enable
o_lost  out  CHANNELS  registered; 1 = channel not LINKED (masked by enable)
o_lost_pulse  out  CHANNELS  one-cycle strobe on LINKED->LOST
o_recover_pulse  out  CHANNELS  one-cycle strobe on RECOVER/LOST->LINKED
o_any_lost  out  1  OR of o_lost
o_all_lost  out  1  every enabled channel lost; 0 if none enabled
o_state  out  2*CHANNELS  per-channel FSM state, ch i at [2i+1:2i]
i_stat_sel  in  4  stats channel select (STATS_EN)
i_stat_clr  in  1  clear all stats counters (STATS_EN)
o_stat_count  out  16  selected channel loss count (STATS_EN)

Behaviour:
- Reset: all FSMs go to WAIT; counters and rec_cnt are 0; every output is 0 during the reset cycle.
- Counter: i_recv=1 -> 0 next cycle. Otherwise it increments, saturating at TIMEOUT.
- expire = (counter==TIMEOUT) && !i_recv. A simultaneous recv wins: counter clears, no expiry.
- WAIT (00): the post-reset or disabled state; counts as lost.
  - recv -> RECOVER with rec_cnt=1, or directly -> LINKED if RECOVER_FRAMES==1.
  - No pulse is emitted on any WAIT entry or exit.
- LINKED (01): expire -> LOST, o_lost_pulse=1 for one cycle.
- LOST (10): recv -> RECOVER with rec_cnt=1; if RECOVER_FRAMES==1 -> LINKED and o_recover_pulse=1.
- RECOVER (11):
  - recv: rec_cnt+1. Reaching RECOVER_FRAMES -> LINKED, o_recover_pulse=1, rec_cnt=0.
  - expire -> LOST, rec_cnt=0, no lost pulse.
- All outputs are registered from next-state, so they change on the same edge as the state.
  - o_lost[i] = (next_state != LINKED) & i_enable[i].
- i_enable[i]=0: channel forced to WAIT, counter 0, o_lost[i]=0, pulses suppressed, excluded from any/all.
  - Re-enable gives o_lost[i]=1 the next cycle with no pulse.
- Latency: last recv sampled at edge t -> with no further recv, state LOST and o_lost high after edge t+TIMEOUT.

Optional Feature:
STATS_EN
- Defined: per-channel 16-bit counters increment on each LINKED->LOST transition and saturate at 0xFFFF.
  - i_stat_clr zeroes all counters; rst also zeroes them.
  - o_stat_count is registered = count[i_stat_sel], 1-cycle latency; 0 if i_stat_sel >= CHANNELS.
- Undefined: ports remain, o_stat_count is tied 0, stats inputs are ignored, no counter logic.

Decomposition:
- Package conn_sup_pkg:
  - 2-bit state encodings ST_WAIT/ST_LINKED/ST_LOST/ST_RECOVER
  - STAT_W=16
  - STAT_SEL_W=4
- Sub-module conn_chan: one counter + FSM + rec_cnt + optional stat counter.
  - conn_supervisor instantiates it CHANNELS times via generate and reduces any/all.

Test Plan:
All scenarios use CHANNELS=4, TIMEOUT=10, RECOVER_FRAMES=3.
1. Reset release, enable=4'hF, no recv -> o_lost=4'hF from the first edge, o_all_lost=1, o_state=8'h00, no pulses for 100 cycles.
2. ch0 recv at edges 0, 5, 10 -> o_state[1:0]=11 after edges 0 and 5; after edge 10 o_lost[0]=0, o_recover_pulse[0]=1 for exactly one cycle, o_all_lost=0.
3. ch0 LINKED with last recv at edge t:
   - recv at edge t+10 keeps o_lost[0]=0.
   - With no recv, o_lost[0]=1 and o_lost_pulse[0]=1 (single cycle) after edge t+10.
4. ch1 LOST, recv at edges 0 and 4, then silence -> state RECOVER then LOST after edge 14, o_lost[1] held 1, no pulses; a later 3-frame burst recovers it.
5. ch2 LINKED, drop i_enable[2] -> o_lost[2]=0 and o_state=WAIT next cycle, no pulse. Re-enable -> o_lost[2]=1 next cycle, no lost pulse. Disable all -> o_all_lost=0.
6. STATS_EN: force 3 loss events on ch1, i_stat_sel=1 -> o_stat_count=3 one cycle later. i_stat_sel=7 -> 0. i_stat_clr pulse -> 0.
